fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_if.sv | 32 +++
 rtl/fifo_wr_arb.sv | 108 ++++++++++
 tb/tb_fifo_wr_arb.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// Bus between the two-requester write arbiter and the FIFO write port.
// master: the arbiter side; slave: the requesters and the FIFO.
interface fifo_wr_arb_if #(
   parameter int DATA_W = 8
);
   logic              req0;
   logic              req1;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic              gnt0;
   logic              gnt1;
   logic              ack0;
   logic              ack1;
   logic              wr_rst_busy;
   logic              full;
   logic              almost_full;
   logic              fifo_wr_en;
   logic [DATA_W-1:0] fifo_wr_data;
   logic              busy;
   logic [15:0]       beats0;
   logic [15:0]       beats1;

   modport master (
      input  req0, req1, data0, data1, wr_rst_busy, full, almost_full,
      output gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_wr_data, busy, beats0, beats1
   );

   modport slave (
      output req0, req1, data0, data1, wr_rst_busy, full, almost_full,
      input  gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_wr_data, busy, beats0, beats1
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter giving two requesters bursts of up to BURST_LEN beats on a FIFO write port.
// Optional per-requester beat statistics are enabled by defining FIFO_WR_ARB_STAT_EN.
module fifo_wr_arb #(
   parameter int BURST_LEN = 16,
   parameter int DATA_W    = 8
) (
   input logic            sys_clk,
   input logic            rst,
   fifo_wr_arb_if.master  bus
);
   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);

   state_t            state, state_nxt;
   logic              gnt_idx, gnt_idx_nxt;
   logic              last_gnt, last_gnt_nxt;
   logic [8:0]        beat_cnt, beat_cnt_nxt;
   logic [1:0]        gnt_q, gnt_nxt;
   logic              req_g;
   logic [DATA_W-1:0] data_g;
   logic              wr;

   assign req_g  = gnt_idx ? bus.req1 : bus.req0;
   assign data_g = gnt_idx ? bus.data1 : bus.data0;

   // Reset forces state to IDLE at once, so the write strobe drops with rst.
   assign wr = (state == XFER) & req_g & ~bus.full & ~bus.wr_rst_busy;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path can infer a latch.
      state_nxt    = state;
      gnt_idx_nxt  = gnt_idx;
      last_gnt_nxt = last_gnt;
      beat_cnt_nxt = beat_cnt;
      case (state)
         IDLE: begin
            if (!bus.wr_rst_busy && (bus.req0 || bus.req1)) begin
               state_nxt    = XFER;
               gnt_idx_nxt  = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
               beat_cnt_nxt = '0;
            end
         end
         XFER: begin
            if (!req_g) begin
               state_nxt    = IDLE;
               last_gnt_nxt = gnt_idx;
            end else if (wr) begin
               beat_cnt_nxt = beat_cnt + 9'd1;
               if (beat_cnt == LAST_BEAT || bus.almost_full) begin
                  state_nxt    = IDLE;
                  last_gnt_nxt = gnt_idx;
               end
            end
         end
      endcase
      gnt_nxt = (state_nxt == XFER) ? (gnt_idx_nxt ? 2'b10 : 2'b01) : 2'b00;
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state    <= IDLE;
         gnt_idx  <= 1'b0;
         last_gnt <= 1'b1;
         beat_cnt <= '0;
         gnt_q    <= 2'b00;
      end else begin
         state    <= state_nxt;
         gnt_idx  <= gnt_idx_nxt;
         last_gnt <= last_gnt_nxt;
         beat_cnt <= beat_cnt_nxt;
         gnt_q    <= gnt_nxt;
      end
   end

   assign bus.gnt0         = gnt_q[0];
   assign bus.gnt1         = gnt_q[1];
   assign bus.ack0         = wr & ~gnt_idx;
   assign bus.ack1         = wr & gnt_idx;
   assign bus.fifo_wr_en   = wr;
   assign bus.fifo_wr_data = wr ? data_g : '0;
   assign bus.busy         = (state == XFER);

`ifdef FIFO_WR_ARB_STAT_EN
   logic [15:0] beats0_q, beats1_q;

   // Saturating write counters, cleared only by rst.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         beats0_q <= '0;
         beats1_q <= '0;
      end else begin
         if (wr && !gnt_idx && beats0_q != 16'hFFFF) beats0_q <= beats0_q + 16'd1;
         if (wr && gnt_idx && beats1_q != 16'hFFFF) beats1_q <= beats1_q + 16'd1;
      end
   end

   assign bus.beats0 = beats0_q;
   assign bus.beats1 = beats1_q;
`else
   assign bus.beats0 = '0;
   assign bus.beats1 = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: three instances (BURST_LEN 16, 4, 1) share one random stimulus and are
// checked every cycle against a burst-level reference model, plus directed scenario tasks.
module tb_fifo_wr_arb;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = '0, data1 = '0;
   logic       full = 1'b0, af = 1'b0, wrb = 1'b0;

   logic [2:0]  o_gnt0, o_gnt1, o_ack0, o_ack1, o_wr, o_busy;
   logic [7:0]  o_data [3];
   logic [15:0] o_b0 [3];
   logic [15:0] o_b1 [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      fifo_wr_arb_if #(.DATA_W(8)) bus ();
      assign bus.req0        = req0;
      assign bus.req1        = req1;
      assign bus.data0       = data0;
      assign bus.data1       = data1;
      assign bus.wr_rst_busy = wrb;
      assign bus.full        = full;
      assign bus.almost_full = af;

      fifo_wr_arb #(
         .BURST_LEN (g == 0 ? 16 : (g == 1 ? 4 : 1)),
         .DATA_W    (8)
      ) u_dut (
         .sys_clk (clk),
         .rst     (rst),
         .bus     (bus)
      );

      assign o_gnt0[g] = bus.gnt0;
      assign o_gnt1[g] = bus.gnt1;
      assign o_ack0[g] = bus.ack0;
      assign o_ack1[g] = bus.ack1;
      assign o_wr[g]   = bus.fifo_wr_en;
      assign o_busy[g] = bus.busy;
      assign o_data[g] = bus.fifo_wr_data;
      assign o_b0[g]   = bus.beats0;
      assign o_b1[g]   = bus.beats1;
   end

   // Reference model: owner of the port (-1 none), beats written in this burst, last owner.
   int m_own [3];
   int m_cnt [3];
   int m_last [3];
   int m_st0 [3];
   int m_st1 [3];

   function automatic int bl_of(int i);
      return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            logic [5:0]  e_ctl, a_ctl;
            logic [7:0]  e_data;
            logic [15:0] e_b0, e_b1;
            logic        rq, w;
            if (rst) begin
               m_own[i]  = -1;
               m_cnt[i]  = 0;
               m_last[i] = 1;
               m_st0[i]  = 0;
               m_st1[i]  = 0;
            end
            rq     = (m_own[i] == 0) ? req0 : req1;
            w      = !rst && (m_own[i] >= 0) && rq && !full && !wrb;
            e_ctl  = {m_own[i] == 0, m_own[i] == 1, w && m_own[i] == 0, w && m_own[i] == 1,
                      w, m_own[i] >= 0};
            e_data = w ? ((m_own[i] == 0) ? data0 : data1) : 8'h00;
`ifdef FIFO_WR_ARB_STAT_EN
            e_b0 = 16'(m_st0[i]);
            e_b1 = 16'(m_st1[i]);
`else
            e_b0 = 16'h0000;
            e_b1 = 16'h0000;
`endif
            a_ctl = {o_gnt0[i], o_gnt1[i], o_ack0[i], o_ack1[i], o_wr[i], o_busy[i]};
            n_cmp++;
            if (a_ctl !== e_ctl) begin
               n_err++;
               $display("FAIL model_ctl inst%0d t=%0t gnt0,gnt1,ack0,ack1,wr_en,busy got %b want %b",
                        i, $time, a_ctl, e_ctl);
            end
            n_cmp++;
            if (o_data[i] !== e_data) begin
               n_err++;
               $display("FAIL model_data inst%0d t=%0t got %h want %h", i, $time, o_data[i], e_data);
            end
            n_cmp++;
            if (o_b0[i] !== e_b0 || o_b1[i] !== e_b1) begin
               n_err++;
               $display("FAIL model_stats inst%0d t=%0t got %0d/%0d want %0d/%0d",
                        i, $time, o_b0[i], o_b1[i], e_b0, e_b1);
            end
            if (!rst) begin
               if (m_own[i] < 0) begin
                  if (!wrb && (req0 || req1)) begin
                     m_own[i] = (req0 && req1) ? 1 - m_last[i] : (req0 ? 0 : 1);
                     m_cnt[i] = 0;
                  end
               end else if (!rq) begin
                  m_last[i] = m_own[i];
                  m_own[i]  = -1;
               end else if (w) begin
                  m_cnt[i]++;
                  if (m_own[i] == 0 && m_st0[i] < 65535) m_st0[i]++;
                  if (m_own[i] == 1 && m_st1[i] < 65535) m_st1[i]++;
                  if (m_cnt[i] == bl_of(i) || af) begin
                     m_last[i] = m_own[i];
                     m_own[i]  = -1;
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      data0 = 8'($urandom);
      data1 = 8'($urandom);
   endtask

   task automatic apply_reset();
      rst  = 1'b1;
      req0 = 1'b0;
      req1 = 1'b0;
      full = 1'b0;
      af   = 1'b0;
      wrb  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_cmp++;
      if ({o_gnt0, o_gnt1, o_ack0, o_ack1, o_wr, o_busy} !== 18'd0) begin
         n_err++;
         $display("FAIL reset_outputs got %b want all zero", {o_gnt0, o_gnt1, o_ack0, o_ack1, o_wr, o_busy});
      end
      apply_reset();
   endtask

   task automatic test_single();
      int len, w, gap;
      apply_reset();
      req0 = 1'b1;
      tick();
      #1;
      n_cmp++;
      if (o_gnt0[0] !== 1'b1) begin
         n_err++;
         $display("FAIL single_first_grant got %b want 1", o_gnt0[0]);
      end
      len = 0;
      w   = 0;
      while (o_gnt0[0] && len < 40) begin
         len++;
         w += int'(o_wr[0]);
         tick();
         #1;
      end
      gap = 0;
      while (!o_gnt0[0] && gap < 10) begin
         gap++;
         tick();
         #1;
      end
      n_cmp++;
      if (len != 16 || w != 16 || gap != 1) begin
         n_err++;
         $display("FAIL single_burst got len=%0d writes=%0d gap=%0d want 16/16/1", len, w, gap);
      end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_contention();
      apply_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      for (int b = 0; b < 4; b++) begin
         int t, w, len;
         logic owner;
         t = 0;
         tick();
         #1;
         while (!o_busy[0] && t < 10) begin
            t++;
            tick();
            #1;
         end
         owner = o_gnt1[0];
         w   = 0;
         len = 0;
         while (o_busy[0] && len < 40) begin
            len++;
            w += int'(o_wr[0]);
            tick();
            #1;
         end
         n_cmp++;
         if (t != 0 || owner !== 1'(b % 2) || w != 16) begin
            n_err++;
            $display("FAIL contention_burst%0d got wait=%0d owner=%b writes=%0d want 0/%0d/16",
                     b, t, owner, w, b % 2);
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      int w, stall, len;
      apply_reset();
      req0 = 1'b1;
      tick();
      w     = 0;
      stall = 0;
      len   = 0;
      #1;
      while (o_gnt0[0] && len < 60) begin
         full = (w == 7 && stall < 5);
         #1;
         if (full) begin
            n_cmp++;
            if (o_wr[0] !== 1'b0 || o_ack0[0] !== 1'b0 || o_gnt0[0] !== 1'b1) begin
               n_err++;
               $display("FAIL backpressure_stall got wr=%b ack=%b gnt=%b want 0/0/1",
                        o_wr[0], o_ack0[0], o_gnt0[0]);
            end
            stall++;
         end
         w += int'(o_wr[0]);
         len++;
         tick();
      end
      full = 1'b0;
      n_cmp++;
      if (w != 16 || stall != 5 || len != 21) begin
         n_err++;
         $display("FAIL backpressure_total got writes=%0d stalls=%0d cycles=%0d want 16/5/21", w, stall, len);
      end
      req0 = 1'b0;
      tick();
   endtask

   task automatic test_early_end();
      int w, len, gap;
      apply_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      w   = 0;
      len = 0;
      #1;
      while (o_gnt0[0] && len < 40) begin
         af = (w == 3);
         #1;
         w += int'(o_wr[0]);
         len++;
         tick();
      end
      af  = 1'b0;
      gap = 0;
      #1;
      while (!o_gnt1[0] && gap < 10) begin
         gap++;
         tick();
         #1;
      end
      n_cmp++;
      if (w != 4 || gap != 1 || o_gnt1[0] !== 1'b1) begin
         n_err++;
         $display("FAIL early_end got writes=%0d gap=%0d gnt1=%b want 4/1/1", w, gap, o_gnt1[0]);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int w, t;
      apply_reset();
      req0 = 1'b1;
      tick();
      w = 0;
      t = 0;
      while (w < 9 && t < 40) begin
         #1;
         w += int'(o_wr[0]);
         t++;
         tick();
      end
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (o_gnt0 !== 3'b000 || o_ack0 !== 3'b000 || o_wr !== 3'b000 || o_busy !== 3'b000) begin
         n_err++;
         $display("FAIL reset_mid got gnt0=%b ack0=%b wr=%b busy=%b want all 0",
                  o_gnt0, o_ack0, o_wr, o_busy);
      end
      tick();
      tick();
      req1 = 1'b1;
      rst  = 1'b0;
      tick();
      #1;
      n_cmp++;
      if (o_gnt0 !== 3'b111 || o_gnt1 !== 3'b000) begin
         n_err++;
         $display("FAIL reset_first_contention got gnt0=%b gnt1=%b want 111/000", o_gnt0, o_gnt1);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_wr_rst_busy();
      apply_reset();
      wrb  = 1'b1;
      req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         n_cmp++;
         if (o_busy !== 3'b000) begin
            n_err++;
            $display("FAIL wrb_no_grant cycle%0d got busy=%b want 000", k, o_busy);
         end
      end
      wrb = 1'b0;
      tick();
      #1;
      n_cmp++;
      if (o_gnt1 !== 3'b111) begin
         n_err++;
         $display("FAIL wrb_release_grant got gnt1=%b want 111", o_gnt1);
      end
      wrb = 1'b1;
      #1;
      n_cmp++;
      if (o_wr !== 3'b000 || o_ack1 !== 3'b000) begin
         n_err++;
         $display("FAIL wrb_stall got wr=%b ack1=%b want 000/000", o_wr, o_ack1);
      end
      tick();
      #1;
      n_cmp++;
      if (o_gnt1 !== 3'b111) begin
         n_err++;
         $display("FAIL wrb_hold got gnt1=%b want 111", o_gnt1);
      end
      wrb  = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   task automatic test_stats();
      int bursts, t;
      logic prev;
      logic [15:0] exp1;
      apply_reset();
      req1   = 1'b1;
      bursts = 0;
      t      = 0;
      prev   = 1'b0;
      while (bursts < 3 && t < 100) begin
         tick();
         #1;
         t++;
         if (prev && !o_gnt1[1]) begin
            bursts++;
            if (bursts == 3) req1 = 1'b0;
         end
         prev = o_gnt1[1];
      end
      tick();
      tick();
      #1;
`ifdef FIFO_WR_ARB_STAT_EN
      exp1 = 16'd12;
`else
      exp1 = 16'd0;
`endif
      n_cmp++;
      if (bursts != 3 || o_b1[1] !== exp1 || o_b0[1] !== 16'd0) begin
         n_err++;
         $display("FAIL stats_bl4 got bursts=%0d beats1=%0d beats0=%0d want 3/%0d/0",
                  bursts, o_b1[1], o_b0[1], exp1);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 0; k < 3000; k++) begin
         req0 = ($urandom % 4) != 0;
         req1 = ($urandom % 4) != 0;
         full = ($urandom % 8) == 0;
         af   = ($urandom % 10) == 0;
         wrb  = ($urandom % 16) == 0;
         rst  = ($urandom % 500) == 0;
         tick();
      end
      rst  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_early_end();
      test_reset_mid();
      test_wr_rst_busy();
      test_stats();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish by t=%0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
